// File: rtl/kamus_pkg.sv
// kamus_pkg: shared types and address-split helper for the kamus L1 data cache
package kamus_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} l1d_state_e;
  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] index;
    logic [31:0] word;
    logic [1:0]  offset;
  } l1d_addr_t;
  function automatic l1d_addr_t l1d_split(input logic [31:0] addr, input int wo, input int iw);
    l1d_addr_t r;
    r.offset = addr[1:0];
    r.word   = (addr >> 2) & ~(32'hFFFF_FFFF << wo);
    r.index  = (addr >> (2 + wo)) & ~(32'hFFFF_FFFF << iw);
    r.tag    = addr >> (2 + wo + iw);
    return r;
  endfunction
endpackage

// File: rtl/kamus_l1d_array.sv
// kamus_l1d_array: tag/valid/data storage with combinational read and byte-enabled word write
module kamus_l1d_array #(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4,
  localparam int WO = $clog2(WORDS_PER_LINE),
  localparam int IW = $clog2(NUM_LINES),
  localparam int TW = 30 - WO - IW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [IW-1:0] rd_idx_i,
  input  logic [WO-1:0] rd_word_i,
  output logic          rd_valid_o,
  output logic [TW-1:0] rd_tag_o,
  output logic [31:0]   rd_data_o,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [WO-1:0] wr_word_i,
  input  logic [3:0]    wr_be_i,
  input  logic [31:0]   wr_data_i,
  input  logic          fill_i,
  input  logic [TW-1:0] fill_tag_i,
  input  logic          clr_i
);
  logic [NUM_LINES-1:0] valid_q;
  logic [TW-1:0] tag_q [NUM_LINES];
  logic [31:0] data_q [NUM_LINES*WORDS_PER_LINE];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[{rd_idx_i, rd_word_i}];
  // a clear on the same edge as a fill wins, so a flushed refill stays invalid
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) valid_q <= '0;
    else if (clr_i) valid_q <= '0;
    else if (fill_i) valid_q[wr_idx_i] <= 1'b1;
  always_ff @(posedge clk_i)
    if (fill_i) tag_q[wr_idx_i] <= fill_tag_i;
  always_ff @(posedge clk_i)
    if (wr_en_i)
      for (int b = 0; b < 4; b++)
        if (wr_be_i[b]) data_q[{wr_idx_i, wr_word_i}][8*b +: 8] <= wr_data_i[8*b +: 8];
endmodule

// File: rtl/kamus_l1d_cache.sv
// kamus_l1d_cache: direct-mapped write-through no-write-allocate L1 data cache
module kamus_l1d_cache import kamus_pkg::*; #(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        l1d_req_i,
  input  logic        l1d_wr_en_i,
  input  logic [31:0] l1d_addr_i,
  input  logic [31:0] l1d_wr_data_i,
  input  logic [3:0]  l1d_be_i,
  input  logic        l1d_flush_i,
  output logic [31:0] l1d_rd_data_o,
  output logic        l1d_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int WO = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 30 - WO - IW;
  l1d_addr_t a;
  l1d_state_e state_q, state_d;
  logic [WO:0] issued_q;
  logic [WO-1:0] returned_q;
  logic flush_pend_q;
  logic [31:0] base_q;
  logic arr_valid, hit, refill, refill_last, wr_en, clr, unused_ok;
  logic [TW-1:0] arr_tag;
  logic [31:0] arr_data;
  assign a = l1d_split(l1d_addr_i, WO, IW);
  assign unused_ok = ^{a.tag[31:TW], a.index[31:IW], a.word[31:WO], a.offset};
  assign hit = arr_valid & (arr_tag == a.tag[TW-1:0]);
  assign refill = state_q == REFILL;
  assign refill_last = refill & mem_rvalid_i & (returned_q == '1);
  assign l1d_rd_data_o = (l1d_req_i & ~l1d_wr_en_i & hit) ? arr_data : '0;
  always_comb begin
    state_d     = state_q;
    l1d_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    case (state_q)
      IDLE: begin
        l1d_stall_o = l1d_req_i & (l1d_wr_en_i | ~hit);
        state_d     = !l1d_req_i ? IDLE : l1d_wr_en_i ? WRITE : hit ? IDLE : REFILL;
      end
      REFILL: begin
        l1d_stall_o = 1'b1;
        mem_req_o   = ~issued_q[WO];
        mem_addr_o  = mem_req_o ? base_q | (32'(issued_q[WO-1:0]) << 2) : '0;
        mem_be_o    = {4{mem_req_o}};
        state_d     = refill_last ? IDLE : REFILL;
      end
      WRITE: begin
        l1d_stall_o = ~mem_ready_i;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {l1d_addr_i[31:2], 2'b00};
        mem_wdata_o = l1d_wr_data_i;
        mem_be_o    = l1d_be_i;
        state_d     = mem_ready_i ? IDLE : WRITE;
      end
      default: state_d = IDLE;
    endcase
  end
  // a flush seen while busy is deferred to the edge that returns to IDLE
  assign clr = state_q == IDLE ? l1d_flush_i : (state_d == IDLE) & (flush_pend_q | l1d_flush_i);
  assign wr_en = refill ? mem_rvalid_i : (state_q == WRITE) & mem_ready_i & hit;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q      <= IDLE;
      issued_q     <= '0;
      returned_q   <= '0;
      flush_pend_q <= 1'b0;
      base_q       <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= (state_d != IDLE) & (flush_pend_q | ((state_q != IDLE) & l1d_flush_i));
      if (state_q == IDLE) begin
        issued_q   <= '0;
        returned_q <= '0;
        base_q     <= {l1d_addr_i[31:WO+2], {(WO+2){1'b0}}};
      end else if (refill) begin
        if (mem_req_o & mem_ready_i) issued_q <= issued_q + 1'b1;
        if (mem_rvalid_i) returned_q <= returned_q + 1'b1;
      end
    end
  kamus_l1d_array #(.NUM_LINES(NUM_LINES), .WORDS_PER_LINE(WORDS_PER_LINE)) u_array (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rd_idx_i  (a.index[IW-1:0]),
    .rd_word_i (a.word[WO-1:0]),
    .rd_valid_o(arr_valid),
    .rd_tag_o  (arr_tag),
    .rd_data_o (arr_data),
    .wr_en_i   (wr_en),
    .wr_idx_i  (refill ? base_q[WO+2 +: IW] : a.index[IW-1:0]),
    .wr_word_i (refill ? returned_q : a.word[WO-1:0]),
    .wr_be_i   (refill ? 4'hF : l1d_be_i),
    .wr_data_i (refill ? mem_rdata_i : l1d_wr_data_i),
    .fill_i    (refill_last),
    .fill_tag_i(base_q[31 -: TW]),
    .clr_i     (clr)
  );
endmodule

// File: tb/tb_kamus_l1d_cache.sv
// tb_kamus_l1d_cache: scoreboard bench with a latency-modelled backing memory
module tb_kamus_l1d_cache;
  logic clk_i = 0, rst_ni = 0;
  logic l1d_req_i = 0, l1d_wr_en_i = 0, l1d_flush_i = 0;
  logic [31:0] l1d_addr_i = 0, l1d_wr_data_i = 0;
  logic [3:0] l1d_be_i = 0;
  logic [31:0] l1d_rd_data_o, mem_addr_o, mem_wdata_o;
  logic l1d_stall_o, mem_req_o, mem_we_o;
  logic [3:0] mem_be_o;
  logic mem_ready_i = 0, mem_rvalid_i = 0;
  logic [31:0] mem_rdata_i = 0;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] be;} mtx_t;
  typedef struct {int due; logic [31:0] d;} rsp_t;
  mtx_t exp_mem[$];
  logic [31:0] exp_load[$];
  rsp_t rq[$];
  logic [31:0] mem [logic [31:0]];
  int checks = 0, failures = 0, nreads = 0, cyc = 0, hold = 0;
  logic prev_stall = 0;
  always #5 clk_i = ~clk_i;
  kamus_l1d_cache #(.NUM_LINES(64), .WORDS_PER_LINE(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .l1d_req_i(l1d_req_i), .l1d_wr_en_i(l1d_wr_en_i),
    .l1d_addr_i(l1d_addr_i), .l1d_wr_data_i(l1d_wr_data_i), .l1d_be_i(l1d_be_i),
    .l1d_flush_i(l1d_flush_i), .l1d_rd_data_o(l1d_rd_data_o), .l1d_stall_o(l1d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );
  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {a[15:0], ~a[15:0]};
  endfunction
  // backing memory: observe the cycle at negedge, drive the next cycle just after posedge
  initial forever begin
    @(negedge clk_i);
    if (rst_ni && mem_req_o && mem_ready_i) begin
      if (mem_we_o) begin
        logic [31:0] w;
        w = mem_rd(mem_addr_o);
        for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
        mem[mem_addr_o] = w;
      end else rq.push_back('{cyc + 2, mem_rd(mem_addr_o)});
    end
    @(posedge clk_i);
    #1;
    cyc++;
    mem_ready_i = !(mem_req_o && hold > 0);
    if (mem_req_o && hold > 0) hold--;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mem_rvalid_i = 1;
      mem_rdata_i = rq[0].d;
      void'(rq.pop_front());
    end else begin
      mem_rvalid_i = 0;
      mem_rdata_i = 0;
    end
  end
  // scoreboard monitor
  initial forever begin
    @(negedge clk_i);
    if (rst_ni) begin
      if (prev_stall) assert (l1d_req_i) else $error("core dropped request while stalled");
      prev_stall = l1d_stall_o;
      if (mem_req_o && mem_ready_i) begin
        if (!mem_we_o) nreads++;
        if (exp_mem.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem actual_addr=%h expected=none", mem_addr_o);
        end else begin
          mtx_t e;
          e = exp_mem.pop_front();
          chk("mem_addr", mem_addr_o, e.addr);
          chk("mem_we", 32'(mem_we_o), 32'(e.we));
          chk("mem_be", 32'(mem_be_o), 32'(e.be));
          if (e.we) chk("mem_wdata", mem_wdata_o, e.wdata);
        end
      end
      if (l1d_req_i && !l1d_wr_en_i && !l1d_stall_o) begin
        if (exp_load.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_load actual=%h expected=none", l1d_rd_data_o);
        end else chk("rd_data", l1d_rd_data_o, exp_load.pop_front());
      end
    end
  end
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, output int stalls);
    l1d_req_i = 1;
    l1d_wr_en_i = we;
    l1d_addr_i = addr;
    l1d_wr_data_i = data;
    l1d_be_i = be;
    stalls = 0;
    forever begin
      @(negedge clk_i);
      if (!l1d_stall_o) break;
      stalls++;
      if (stalls > 100) begin
        checks++;
        failures++;
        $display("FAIL stall_timeout addr=%h actual=%0d required<=100", addr, stalls);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    l1d_req_i = 0;
    l1d_wr_en_i = 0;
  endtask
  task automatic load(input logic [31:0] addr, input logic [31:0] exp, input int exp_stalls,
                      input int exp_reads);
    int st, r0;
    exp_load.push_back(exp);
    for (int i = 0; i < exp_reads; i++)
      exp_mem.push_back('{(addr & ~32'hF) + 32'(4 * (i % 4)), 1'b0, 32'h0, 4'hF});
    r0 = nreads;
    access(1'b0, addr, 32'h0, 4'h0, st);
    chk("load_stalls", 32'(st), 32'(exp_stalls));
    chk("load_reads", 32'(nreads - r0), 32'(exp_reads));
  endtask
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                       input int exp_stalls);
    int st, r0;
    exp_mem.push_back('{addr & ~32'h3, 1'b1, data, be});
    r0 = nreads;
    access(1'b1, addr, data, be, st);
    chk("store_stalls", 32'(st), 32'(exp_stalls));
    chk("store_reads", 32'(nreads - r0), 32'h0);
  endtask
  initial begin
    mem[32'h100] = 32'hDEAD_BEEF;
    #3;
    chk("rst_stall", 32'(l1d_stall_o), 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_mem_we", 32'(mem_we_o), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk("rst_mem_be", 32'(mem_be_o), 32'h0);
    chk("rst_rd_data", l1d_rd_data_o, 32'h0);
    @(posedge clk_i);
    #1 rst_ni = 1;
    repeat (2) @(posedge clk_i);
    #1;
    load(32'h100, 32'hDEAD_BEEF, 7, 4);
    load(32'h104, 32'h0104_FEFB, 0, 0);
    hold = 2;
    store(32'h104, 32'h1122_3344, 4'b0011, 3);
    load(32'h104, 32'h0104_3344, 0, 0);
    store(32'h2000, 32'hCAFE_F00D, 4'hF, 1);
    load(32'h2000, 32'hCAFE_F00D, 7, 4);
    // flush during the refill: the line is dropped and the held load refills again
    fork
      load(32'h300, 32'h0300_FCFF, 14, 8);
      begin
        repeat (3) @(posedge clk_i);
        #1 l1d_flush_i = 1;
        @(posedge clk_i);
        #1 l1d_flush_i = 0;
      end
    join
    l1d_flush_i = 1;
    @(posedge clk_i);
    #1 l1d_flush_i = 0;
    load(32'h300, 32'h0300_FCFF, 7, 4);
    load(32'h100, 32'hDEAD_BEEF, 7, 4);
    load(32'h500, 32'h0500_FAFF, 7, 4);
    load(32'h100, 32'hDEAD_BEEF, 7, 4);
    repeat (5) @(posedge clk_i);
    #1;
    chk("mem_queue_empty", 32'(exp_mem.size()), 32'h0);
    chk("load_queue_empty", 32'(exp_load.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
